// File: rtl/uart_rx_pkg.sv
// Shared UART receiver constants: default widths, the minimum usable
// oversampling ratio, the idle line level and the 3-way majority vote.
package uart_rx_pkg;

    localparam int   PRESCALE_W   = 6;
    localparam int   BIT_CNT_W    = 4;
    localparam int   MIN_PRESCALE = 6;
    localparam logic IDLE_LEVEL   = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_bit_sampler_if.sv
// Bundle between the RX FSM/deserializer side (master) and the bit sampler (slave).
interface rx_bit_sampler_if #(
    parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W,
    parameter int BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W
);
    logic                  RX_IN;
    logic                  Enable;
    logic [PRESCALE_W-1:0] Prescale;
    logic [PRESCALE_W-1:0] edge_count;
    logic [BIT_CNT_W-1:0]  bit_count;
    logic                  sampled_bit;
    logic                  sample_valid;

    modport master (
        output RX_IN, Enable, Prescale,
        input  edge_count, bit_count, sampled_bit, sample_valid
    );

    modport slave (
        input  RX_IN, Enable, Prescale,
        output edge_count, bit_count, sampled_bit, sample_valid
    );
endinterface

// File: rtl/uart_edge_bit_counter.sv
// Edge counter within a bit period and saturating bit counter within a frame.
// Both clear whenever the frame is inactive or the oversampling ratio is unusable.
module uart_edge_bit_counter #(
    parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W,
    parameter int BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Enable,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  active,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_CNT_W-1:0]  bit_count
);
    localparam logic [BIT_CNT_W-1:0] BIT_MAX = '1;

    logic [PRESCALE_W-1:0] last_edge;

    assign active    = Enable && (Prescale >= PRESCALE_W'(uart_rx_pkg::MIN_PRESCALE));
    assign last_edge = Prescale - PRESCALE_W'(1);

    // >= rather than == so a Prescale reduced mid-frame wraps at once.
    always_ff @(posedge CLK) begin
        if (RST || !active) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (edge_count >= last_edge) begin
            edge_count <= '0;
            if (bit_count != BIT_MAX) begin
                bit_count <= bit_count + BIT_CNT_W'(1);
            end
        end else begin
            edge_count <= edge_count + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/rx_bit_sampler.sv
// UART RX oversampling front end: three samples around the bit centre,
// majority-voted into a registered sampled_bit plus a one-cycle valid pulse.
module rx_bit_sampler #(
    parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W,
    parameter int BIT_CNT_W  = uart_rx_pkg::BIT_CNT_W
) (
    input logic              CLK,
    input logic              RST,
    rx_bit_sampler_if.slave  bus
);
    logic                  active;
    logic [PRESCALE_W-1:0] edge_count;
    logic [BIT_CNT_W-1:0]  bit_count;
    logic [PRESCALE_W-1:0] mid;
    logic                  s1;
    logic                  s2;
    logic                  sampled_bit;
    logic                  sample_valid;

    uart_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_counter (
        .CLK        (CLK),
        .RST        (RST),
        .Enable     (bus.Enable),
        .Prescale   (bus.Prescale),
        .active     (active),
        .edge_count (edge_count),
        .bit_count  (bit_count)
    );

    assign mid = bus.Prescale >> 1;

    // Samples at mid-2 and mid-1 are held; the vote uses the live line at mid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1           <= uart_rx_pkg::IDLE_LEVEL;
            s2           <= uart_rx_pkg::IDLE_LEVEL;
            sampled_bit  <= uart_rx_pkg::IDLE_LEVEL;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (!active) begin
                s1 <= uart_rx_pkg::IDLE_LEVEL;
                s2 <= uart_rx_pkg::IDLE_LEVEL;
            end else begin
                if (edge_count == mid - PRESCALE_W'(2)) begin
                    s1 <= bus.RX_IN;
                end
                if (edge_count == mid - PRESCALE_W'(1)) begin
                    s2 <= bus.RX_IN;
                end
                if (edge_count == mid) begin
                    sampled_bit  <= uart_rx_pkg::majority3(s1, s2, bus.RX_IN);
                    sample_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.edge_count   = edge_count;
    assign bus.bit_count    = bit_count;
    assign bus.sampled_bit  = sampled_bit;
    assign bus.sample_valid = sample_valid;

endmodule

// File: doc/rx_bit_sampler.md
# rx_bit_sampler

Oversampling front end of the UART receiver. It counts oversampling clock edges within each bit period and counts bit periods within a frame. It takes three samples of the serial line around the bit centre and produces a majority-voted `sampled_bit`. The deserializer, parity check and stop check sit downstream and use `sampled_bit`, `edge_count` and `bit_count` from this block. The deserializer captures `sampled_bit` when `edge_count == Prescale-1`, so `sampled_bit` must be stable by then.

## Interface
- `PRESCALE_W`, default 6: width of `Prescale` and `edge_count`.
- `BIT_CNT_W`, default 4: width of `bit_count`. This covers the longest frame: start, 8 data bits, parity, stop.
- `CLK`, in, 1: the single clock. It runs at the oversampling rate.
- `RST`, in, 1: reset. Synchronous, active-high. It clears all state on the `CLK` edge where it is high.
- `RX_IN`, in, 1: serial line. It is already synchronised upstream.
- `Enable`, in, 1: frame active. Driven by the RX FSM.
- `Prescale`, in, `PRESCALE_W`: oversampling ratio. Legal values are even and ≥6; nominal values are 8, 16 and 32.
- `edge_count`, out, `PRESCALE_W`: edge index within the current bit, 0..Prescale-1.
- `bit_count`, out, `BIT_CNT_W`: bit index within the frame.
- `sampled_bit`, out, 1: majority-voted bit value, registered.
- `sample_valid`, out, 1: one-cycle pulse on the cycle after `sampled_bit` updates.

## Operation
- **Reset values:** `edge_count`=0, `bit_count`=0, `sampled_bit`=1 (idle line level), `sample_valid`=0, internal samples s1 and s2 = 1. `RST` has priority over everything else.
- **Enable low:** `edge_count` and `bit_count` load 0 on the next edge. `sampled_bit` holds. `sample_valid`=0.
- **Enable high, edge counting:**
  - Wrap condition: `edge_count >= Prescale-1`.
  - On wrap, `edge_count` goes to 0 and `bit_count` increments.
  - Otherwise `edge_count` increments.
  - The `>=` compare makes a mid-frame `Prescale` decrease wrap on the next edge instead of running past the new limit.
- **bit_count at the top:** it saturates at 2^BIT_CNT_W-1 and never wraps.
- **Sample points:** M = Prescale>>1.
  - When `edge_count`==M-2, register RX_IN into s1.
  - When `edge_count`==M-1, register RX_IN into s2.
  - When `edge_count`==M, `sampled_bit` ← majority(s1, s2, RX_IN). Majority is (a&b)|(a&c)|(b&c). `sample_valid` is 1 on the following cycle.
- **Illegal Prescale (< 6):** counters are held at 0. No samples are taken. `sample_valid` stays 0. `sampled_bit` holds.
- **Odd Prescale:** M truncates. Behaviour is otherwise the same; this is not a supported operating point.
- **Enable dropped mid-bit:** counters clear on the next edge. Partial samples are discarded. `sampled_bit` keeps its last voted value.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- **sampled_bit latency:** it changes on the edge that ends the `edge_count`==M cycle. It is stable from `edge_count`==M+1 through `edge_count`==M of the next bit, which covers the deserializer capture at Prescale-1.
- **Counter start:** the first `edge_count` increment occurs on the first edge with `Enable` high. `edge_count`=1 is seen one cycle after `Enable` rises.
- **Enable and wrap in the same cycle:** if `Enable` falls in the cycle where the wrap condition holds, the clear wins. Both counters go to 0 and there is no `bit_count` increment.
- **Bit period:** exactly Prescale cycles per bit, measured as a 0→0 `edge_count` period.

## Structure
- **Package `uart_rx_pkg`:** `PRESCALE_W`, `BIT_CNT_W`, `MIN_PRESCALE`=6, and the idle line level constant (1). The deserializer and parity/stop checkers use it as well.
- **Sub-module `uart_edge_bit_counter`:** contains the edge and bit counters, the wrap compare and saturation.
- **In the top:** the sample registers, the majority vote and `sample_valid` logic.

## Test plan
- **Reset:** `RST`=1 for 2 cycles with `RX_IN`=0 and `Enable`=1 → `edge_count`=0, `bit_count`=0, `sampled_bit`=1, `sample_valid`=0. Counting starts on the first edge after `RST`=0.
- **Clean frame:** Prescale=8, `Enable`=1, line carries 0x5A LSB-first after a start bit. Each bit → `sample_valid` pulses 9 cycles apart… no: one pulse per 8 cycles, with the pulse while `edge_count`=5. `sampled_bit` sequence is 0,0,1,0,1,1,0,1,0. `bit_count` reaches 9.
- **Glitch rejection:** Prescale=16, line held 1 except `RX_IN`=0 only at `edge_count`=7 → vote=1. `RX_IN`=0 at 6 and 8 → vote=0.
- **Enable drop mid-bit:** `Enable`=0 at `edge_count`=3, `bit_count`=4 → both counters are 0 next cycle, no `sample_valid`, `sampled_bit` unchanged.
- **Prescale edge cases:** Prescale=4 → counters stuck at 0 and no `sample_valid`. Prescale changed from 32 to 8 while `edge_count`=20 → wrap to 0 on the next edge and `bit_count`+1.
- **Saturation:** `Enable` held for 20 bit periods at Prescale=8 → `bit_count` stops at 15 while `edge_count` keeps wrapping.
